// File: rtl/poly1305_reduce_limb.sv
// Reduces a 258-bit product modulo p = 2^130 - 5 with a limb-serial fold, a short fold and one subtract.
// Optional REDUCE_CNT_EN adds a 32-bit count of completed reductions.
module poly1305_reduce_limb #(
    parameter int unsigned LIMB     = 16,
    parameter int unsigned IN_BITS  = 258,
    parameter int unsigned OUT_BITS = 130
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_BITS-1:0]  prod_in,
    output logic [OUT_BITS-1:0] result_out,
    output logic                busy,
    output logic                done
`ifdef REDUCE_CNT_EN
    ,
    output logic [31:0]         reduce_count
`endif
);

    localparam int unsigned L  = (OUT_BITS + LIMB - 1) / LIMB;
    localparam int unsigned W  = L * LIMB;
    localparam int unsigned KW = $clog2(L);
    localparam int unsigned SW = LIMB + 3;
    localparam int unsigned XW = OUT_BITS + 1;
    localparam logic [OUT_BITS-1:0] P = {{(OUT_BITS-3){1'b1}}, 3'b011};

    typedef enum logic [1:0] {IDLE, FOLD, FOLD2, SUB} state_t;

    state_t          state;
    logic [W-1:0]    lo;
    logic [W-1:0]    hi;
    logic [W-1:0]    x1;
    logic [2:0]      carry;
    logic [KW-1:0]   k;
    logic [XW-1:0]   x2;
    logic [SW-1:0]   s;
    logic [W-OUT_BITS+2:0] x1_top;

    always_comb begin
        s = SW'(lo[LIMB-1:0]) + SW'(hi[LIMB-1:0]) * SW'(5) + SW'(carry);
    end

    // Everything above bit 129 (including the final carry) folds back with weight 5.
    always_comb begin
        x1_top = {carry, x1[W-1:OUT_BITS]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lo         <= '0;
            hi         <= '0;
            x1         <= '0;
            carry      <= '0;
            k          <= '0;
            x2         <= '0;
            result_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo    <= W'(prod_in[OUT_BITS-1:0]);
                        hi    <= W'(prod_in[IN_BITS-1:OUT_BITS]);
                        carry <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    // Limbs shift in from the top so limb k lands at position k after L cycles.
                    x1    <= {s[LIMB-1:0], x1[W-1:LIMB]};
                    carry <= s[SW-1:LIMB];
                    lo    <= lo >> LIMB;
                    hi    <= hi >> LIMB;
                    k     <= k + 1'b1;
                    if (k == KW'(L - 1)) begin
                        state <= FOLD2;
                    end
                end
                FOLD2: begin
                    x2    <= XW'(x1[OUT_BITS-1:0]) + XW'(x1_top) * XW'(5);
                    state <= SUB;
                end
                default: begin
                    // x2 < 2^130 + 15, so x2 - p fits in 130 bits and modular subtraction is exact.
                    if (x2[OUT_BITS] || (x2[OUT_BITS-1:0] >= P)) begin
                        result_out <= x2[OUT_BITS-1:0] - P;
                    end else begin
                        result_out <= x2[OUT_BITS-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef REDUCE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reduce_count <= '0;
        end else if (state == SUB) begin
            reduce_count <= reduce_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/poly1305_reduce_limb.md
Name: poly1305_reduce_limb

Overview:
- Consumer end of the 130x128 limb multiplier interface.
- Accepts the 258-bit product on a start pulse, normally wired to the multiplier's done pulse.
- Reduces the product modulo p = 2^130 - 5 using a limb-serial fold, a second short fold and one conditional subtract.
- Returns the fully reduced 130-bit value with a busy/done handshake that mirrors the multiplier's.

Parameters:
- LIMB, 16: fold datapath width in bits per cycle; legal values 8, 16, 32.
- IN_BITS, 258: product width; fixed by the multiplier.
- OUT_BITS, 130: result width; fixed by p.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only when busy=0.
- prod_in  in  258  product to reduce; sampled on the accepting edge only.
- result_out  out  130  reduced value, always < p; holds until the next done.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result_out is valid in that cycle.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, result_out=0, state=IDLE, all internal registers 0.
- Reset mid-operation aborts immediately, with no done pulse. The in-flight operation is lost.
- Limb count: L = ceil(130/LIMB), which is 9 for LIMB=16.
- Working registers:
  - lo = prod_in[129:0], zero-extended to L*LIMB bits.
  - hi = prod_in[257:130], zero-extended to L*LIMB bits.
  - carry register, 3 bits.
  - x1 register, 132 bits.
- IDLE: on start=1, capture lo and hi, clear carry and limb index k, set busy=1, go to FOLD.
- FOLD, L cycles, one per k = 0..L-1:
  - s = lo_k + 5*hi_k + carry.
  - x1 limb k <= s[LIMB-1:0]; carry <= s >> LIMB.
  - Bound: carry <= 5 always.
  - After k = L-1, the final carry is appended above the top limb. x1 < 2^132 is guaranteed.
  - Then go to FOLD2.
- FOLD2, 1 cycle: x2 = x1[129:0] + 5*x1[131:130], held in a 131-bit register. x2 < 2^130 + 15. Go to SUB.
- SUB, 1 cycle:
  - If x2 >= p, result_out <= x2 - p; else result_out <= x2[129:0].
  - A single subtract always suffices.
  - Same edge: done <= 1, busy <= 0, go to IDLE.
- Latency: done is high L+2 cycles after the accepting edge, i.e. 11 cycles for LIMB=16.
- Throughput: one operation per L+3 cycles.
- Back-to-back: start is accepted in the cycle done is high, because busy is already 0.
- start while busy=1 is ignored. There is no queue, no error, and the current operation is unaffected.
- prod_in may change freely after the accepting edge.
- done is never high for two consecutive cycles.
- All arithmetic is unsigned. There is no overflow path; the register widths above are mandatory minimums.

Optional Feature:
- Macro: REDUCE_CNT_EN.
- Defined:
  - Adds output port reduce_count, 32 bits.
  - Increments on every done pulse and wraps 0xFFFFFFFF to 0.
  - Reset value 0. Aborted operations do not count.
- Undefined: the port and counter are absent, and the remaining behaviour is identical.

Test Plan:
- prod_in=0, start pulse -> done exactly 11 cycles after the accepting edge (LIMB=16); result_out=0; busy high in between.
- prod_in=2^130 -> result_out=5. prod_in=2^130-1 -> result_out=4.
- prod_in=2^130-5 -> result_out=0. prod_in=2^130-6 -> result_out=2^130-6, unchanged.
- prod_in=2^258-1 -> result_out=2^128+4 (exercises maximum carries and the SUB path). Random 130x128 operand products -> result_out matches the (a*b) mod p reference model, over 10k cases.
- start re-pulsed with a different prod_in while busy -> ignored, first result delivered. start on the done cycle -> accepted, second done 12 cycles after the first.
- reset asserted at FOLD k=4 -> busy, done and result_out go to 0 asynchronously, no done pulse. Operation after release is correct. With REDUCE_CNT_EN, count = completed operations only.
